lsu_dcache_port: RTL
====================

Name: lsu_dcache_port

Overview:
- Load/store unit front-end directly upstream of the data cache.
- Takes one memory op at a time from the execute stage and produces a word-aligned address, byte enables and lane-replicated write data.
- Drives the cache's stb/stall/ack/err handshake.
- Returns sign- or zero-extended load data, or a misalignment/bus-error indication, to writeback as a one-cycle completion pulse.

Parameters:
- XLEN, 32, data/address width; only 32 is supported.
- TIMEOUT, 255, max cycles in WAIT before a forced bus error; the counter is $clog2(TIMEOUT+1) bits wide.

Ports:
- i_clk  in  1  clock; all logic on the rising edge.
- i_reset_n  in  1  synchronous active-low reset.
- i_valid  in  1  execute presents an op.
- i_store  in  1  1=store, 0=load.
- i_op  in  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- i_addr  in  XLEN  byte address.
- i_wdata  in  XLEN  store data, right-aligned.
- i_rd  in  5  destination register tag.
- o_ready  out  1  op can be accepted this cycle.
- o_done  out  1  one-cycle completion pulse.
- o_rdata  out  XLEN  extended load data, valid with o_done.
- o_rd  out  5  tag of the completing op.
- o_misaligned  out  1  alignment fault, valid with o_done.
- o_bus_err  out  1  bus error, timeout or illegal op, valid with o_done.
- o_wb_stb  out  1  request strobe to the cache.
- o_wb_we  out  1  write request.
- o_addr  out  XLEN  word-aligned address; bits [1:0] are always 0.
- o_data  out  XLEN  lane-replicated write data.
- o_be  out  XLEN/8  byte enables.
- i_wb_stall  in  1  cache cannot take the strobe.
- i_wb_ack  in  1  cache completion.
- i_wb_err  in  1  cache/memory error.
- i_data  in  XLEN  cache read word, valid with i_wb_ack.

Behaviour:
- States: IDLE, REQ, WAIT, RESP.
- o_ready = (state==IDLE).
- Reset (i_reset_n=0 at an edge):
  - state=IDLE.
  - o_wb_stb, o_wb_we, o_done, o_misaligned, o_bus_err = 0.
  - o_addr, o_data, o_rdata = 0; o_be=0; o_rd=0; timeout counter=0.
  - Applies mid-transaction: stb drops next cycle, and any later ack/err arriving in IDLE is ignored.
- Accept, when i_valid & o_ready at edge N:
  - Latch store, op, addr[1:0], wdata, rd.
  - Misaligned means H/HU with addr[0]=1, or W with addr[1:0]!=0.
  - Illegal means op in {011,110,111}, or a store with op[2]=1.
  - Misaligned or illegal: go to RESP; no bus cycle; o_misaligned or o_bus_err set accordingly.
  - Otherwise: go to REQ; o_wb_stb=1 from cycle N+1.
- Byte enables: B = 4'b0001<<a[1:0]; H = 4'b0011<<a[1:0]; W = 4'b1111.
- Store data: B = {4{wdata[7:0]}}; H = {2{wdata[15:0]}}; W = wdata. Loads drive o_data=0 and o_wb_we=0.
- REQ:
  - o_wb_stb, o_wb_we, o_addr, o_data and o_be are held stable while i_wb_stall=1.
  - On a cycle with i_wb_stall=0: the request is taken; stb drops next cycle; go to WAIT.
  - i_wb_ack/i_wb_err may arrive in that same cycle: complete directly to RESP.
- WAIT:
  - i_wb_err=1 (takes priority over ack): o_bus_err=1; go to RESP.
  - Else i_wb_ack=1: capture i_data; go to RESP.
  - The counter increments each WAIT cycle. When it reaches TIMEOUT with no ack: o_bus_err=1; go to RESP; counter cleared.
- Load extraction: w = i_data >> (8*a[1:0]). B = sext(w[7:0]); BU = zext(w[7:0]); H = sext(w[15:0]); HU = zext(w[15:0]); W = i_data.
- RESP:
  - o_done=1 for exactly one cycle, with o_rd, o_rdata, o_misaligned and o_bus_err.
  - o_rdata=0 for stores and for faults.
  - Next state IDLE. o_misaligned/o_bus_err clear with o_done.
- Latency, no stall, ack in the cycle after stb:
  - Accept at N, stb at N+1, ack at N+2, o_done at N+3.
  - Faulted ops: o_done at N+1.
- Ack or err seen in IDLE or RESP is discarded.

Test Plan:
- LB addr 0x103, i_data 0x80AA_BBCC, ack 1 cycle after stb -> o_be=4'b1000, o_addr=0x100, o_done 3 cycles after accept, o_rdata=0xFFFF_FF80.
- SH addr 0x202, wdata 0x1234_5678, i_wb_stall high 3 cycles -> stb/addr/be/data stable 4 cycles, o_data=0x5678_5678, o_be=4'b1100, o_done with o_rdata=0.
- LW addr 0x301 -> no o_wb_stb ever, o_done the cycle after accept, o_misaligned=1; LHU addr 0x302, i_data 0xBEEF_0000 -> o_rdata=0x0000_BEEF.
- LW with i_wb_err and i_wb_ack both high in WAIT -> o_bus_err=1, o_rdata=0; separately, no ack with TIMEOUT=4 -> o_bus_err after 4 WAIT cycles.
- i_reset_n low for one cycle while in WAIT, then a stray ack -> all outputs 0, o_ready=1, no o_done; next LBU addr 0x0 completes normally.
- Back-to-back ops with i_valid held high -> the second op is accepted only on the cycle o_ready returns after o_done; o_rd matches each op in order.

Source files
------------

// File: rtl/lsu_dcache_port.sv
// Load/store front-end to the data cache: aligns requests, builds byte enables and replicated store data,
// extends load data. One op in flight; faulted ops complete one cycle after accept, bus ops the cycle after ack/err.
module lsu_dcache_port #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_valid,
    input  logic              i_store,
    input  logic [2:0]        i_op,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [4:0]        i_rd,
    output logic              o_ready,
    output logic              o_done,
    output logic [XLEN-1:0]   o_rdata,
    output logic [4:0]        o_rd,
    output logic              o_misaligned,
    output logic              o_bus_err,
    output logic              o_wb_stb,
    output logic              o_wb_we,
    output logic [XLEN-1:0]   o_addr,
    output logic [XLEN-1:0]   o_data,
    output logic [XLEN/8-1:0] o_be,
    input  logic              i_wb_stall,
    input  logic              i_wb_ack,
    input  logic              i_wb_err,
    input  logic [XLEN-1:0]   i_data
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CW-1:0]     tmo_cnt;
    logic [CW-1:0]     tmo_cnt_nxt;

    logic              op_store;
    logic [2:0]        op_code;
    logic [1:0]        op_lane;

    logic              in_illegal;
    logic              in_misaligned;
    logic [XLEN/8-1:0] in_be;
    logic [XLEN-1:0]   in_data;

    logic              resp_mis;
    logic              resp_err;
    logic              resp_ack;

    logic [7:0]        ld_byte;
    logic [15:0]       ld_half;
    logic [XLEN-1:0]   load_val;

    assign o_ready = (state == IDLE);

    // Decode of the op currently presented by execute.
    always_comb begin
        in_illegal    = (i_op == 3'b011) || (i_op == 3'b110) || (i_op == 3'b111) || (i_store && i_op[2]);
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_data       = i_wdata;
        case (i_op[1:0])
            2'b00: begin
                in_be   = 4'b0001 << i_addr[1:0];
                in_data = {4{i_wdata[7:0]}};
            end
            2'b01: begin
                in_misaligned = i_addr[0];
                in_be         = 4'b0011 << i_addr[1:0];
                in_data       = {2{i_wdata[15:0]}};
            end
            default: in_misaligned = |i_addr[1:0];
        endcase
        if (in_illegal) begin
            in_misaligned = 1'b0;
        end
        if (!i_store) begin
            in_data = '0;
        end
    end

    // Halfword lane only needs addr[1]; legal halfwords are 2-byte aligned.
    always_comb begin
        ld_byte = i_data[{op_lane, 3'b000} +: 8];
        ld_half = i_data[{op_lane[1], 4'b0000} +: 16];
        case (op_code)
            3'b000:  load_val = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_val = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_val = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_val = {{(XLEN-16){1'b0}}, ld_half};
            default: load_val = i_data;
        endcase
    end

    always_comb begin
        state_nxt   = state;
        tmo_cnt_nxt = tmo_cnt;
        resp_mis    = 1'b0;
        resp_err    = 1'b0;
        resp_ack    = 1'b0;
        case (state)
            IDLE: begin
                if (i_valid) begin
                    if (in_misaligned || in_illegal) begin
                        state_nxt = RESP;
                        resp_mis  = in_misaligned;
                        resp_err  = in_illegal;
                    end else begin
                        state_nxt = REQ;
                    end
                end
            end
            REQ: begin
                if (!i_wb_stall) begin
                    if (i_wb_err) begin
                        state_nxt = RESP;
                        resp_err  = 1'b1;
                    end else if (i_wb_ack) begin
                        state_nxt = RESP;
                        resp_ack  = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (i_wb_err) begin
                    state_nxt   = RESP;
                    resp_err    = 1'b1;
                    tmo_cnt_nxt = '0;
                end else if (i_wb_ack) begin
                    state_nxt   = RESP;
                    resp_ack    = 1'b1;
                    tmo_cnt_nxt = '0;
                end else if (tmo_cnt == TMO_LAST) begin
                    state_nxt   = RESP;
                    resp_err    = 1'b1;
                    tmo_cnt_nxt = '0;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CW'(1);
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            state   <= state_nxt;
            tmo_cnt <= tmo_cnt_nxt;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            o_done       <= 1'b0;
            o_misaligned <= 1'b0;
            o_bus_err    <= 1'b0;
            o_rdata      <= '0;
            o_rd         <= '0;
            o_wb_stb     <= 1'b0;
            o_wb_we      <= 1'b0;
            o_addr       <= '0;
            o_data       <= '0;
            o_be         <= '0;
            op_store     <= 1'b0;
            op_code      <= '0;
            op_lane      <= '0;
        end else begin
            // Completion fields are only non-zero during the single RESP cycle.
            o_done       <= (state_nxt == RESP);
            o_misaligned <= resp_mis;
            o_bus_err    <= resp_err;
            o_rdata      <= (resp_ack && !op_store) ? load_val : '0;
            if (state == IDLE && i_valid) begin
                op_store <= i_store;
                op_code  <= i_op;
                op_lane  <= i_addr[1:0];
                o_rd     <= i_rd;
                if (!in_illegal && !in_misaligned) begin
                    o_wb_stb <= 1'b1;
                    o_wb_we  <= i_store;
                    o_addr   <= {i_addr[XLEN-1:2], 2'b00};
                    o_be     <= in_be;
                    o_data   <= in_data;
                end
            end else if (state == REQ && !i_wb_stall) begin
                o_wb_stb <= 1'b0;
                o_wb_we  <= 1'b0;
            end
        end
    end

endmodule
